// File: rtl/cache_controller.sv
// cache_controller: miss handler arbitrating split I/D caches onto one line-wide memory port.
// Optional saturating miss counters are enabled by defining CACHE_CTRL_MISS_CNT_EN.
module cache_controller #(
    parameter int unsigned LINE_W  = 64,
    parameter int unsigned LADDR_W = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [15:0]        i_addr,
    input  logic               i_hit,
    output logic               i_rdy,
    output logic               i_fill_we,
    input  logic [15:0]        d_addr,
    input  logic               d_re,
    input  logic               d_we,
    input  logic               d_hit,
    input  logic               d_dirty,
    input  logic [10:0]        d_victim_tag,
    input  logic [LINE_W-1:0]  d_victim_line,
    output logic               d_rdy,
    output logic               d_fill_we,
    output logic [LADDR_W-1:0] m_addr,
    output logic               m_re,
    output logic               m_we,
    output logic [LINE_W-1:0]  m_wdata,
    input  logic [LINE_W-1:0]  m_rdata,
    input  logic               m_rdy
`ifdef CACHE_CTRL_MISS_CNT_EN
    ,
    output logic [15:0]        i_miss_cnt,
    output logic [15:0]        d_miss_cnt
`endif
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WB   = 2'd1,
        D_FILL = 2'd2,
        I_FILL = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [LADDR_W-1:0]   d_line_q, d_line_d;
    logic [LINE_W-1:0]    m_wdata_q, m_wdata_d;
    logic                 m_re_q, m_re_d;
    logic                 m_we_q, m_we_d;
    logic                 d_ok_c;
    logic                 d_miss_c;
    logic                 i_miss_c;

    // Fill data goes straight from memory into the cache arrays; low address bits select words there.
    logic unused_inputs;
    assign unused_inputs = ^{m_rdata, i_addr[1:0], d_addr[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_addr_q  <= '0;
            d_line_q  <= '0;
            m_wdata_q <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_addr_q  <= m_addr_d;
            d_line_q  <= d_line_d;
            m_wdata_q <= m_wdata_d;
            m_re_q    <= m_re_d;
            m_we_q    <= m_we_d;
        end
    end

    // Next state, latched memory request, and same-cycle ready/fill strobes.
    always_comb begin
        state_d   = state_q;
        m_addr_d  = m_addr_q;
        d_line_d  = d_line_q;
        m_wdata_d = m_wdata_q;
        m_re_d    = 1'b0;
        m_we_d    = 1'b0;
        i_rdy     = 1'b0;
        d_rdy     = 1'b0;
        i_fill_we = 1'b0;
        d_fill_we = 1'b0;
        d_miss_c  = 1'b0;
        i_miss_c  = 1'b0;
        d_ok_c    = ~(d_re | d_we) | d_hit;

        unique case (state_q)
            IDLE: begin
                d_rdy = rst_n & d_ok_c;
                i_rdy = rst_n & d_ok_c & i_hit;
                if (!d_ok_c) begin
                    d_miss_c = 1'b1;
                    d_line_d = LADDR_W'(d_addr[15:2]);
                    if (d_dirty) begin
                        state_d   = D_WB;
                        m_we_d    = 1'b1;
                        m_addr_d  = LADDR_W'({d_victim_tag, d_addr[4:2]});
                        m_wdata_d = d_victim_line;
                    end else begin
                        state_d  = D_FILL;
                        m_re_d   = 1'b1;
                        m_addr_d = LADDR_W'(d_addr[15:2]);
                    end
                end else if (!i_hit) begin
                    i_miss_c = 1'b1;
                    state_d  = I_FILL;
                    m_re_d   = 1'b1;
                    m_addr_d = LADDR_W'(i_addr[15:2]);
                end
            end
            D_WB: begin
                if (m_rdy) begin
                    state_d  = D_FILL;
                    m_re_d   = 1'b1;
                    m_addr_d = d_line_q;
                end else begin
                    m_we_d = 1'b1;
                end
            end
            D_FILL: begin
                if (m_rdy) begin
                    d_fill_we = 1'b1;
                    state_d   = IDLE;
                end else begin
                    m_re_d = 1'b1;
                end
            end
            I_FILL: begin
                if (m_rdy) begin
                    i_fill_we = 1'b1;
                    state_d   = IDLE;
                end else begin
                    m_re_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_re    = m_re_q;
    assign m_we    = m_we_q;

`ifdef CACHE_CTRL_MISS_CNT_EN
    logic [CNT_W-1:0] i_miss_cnt_q, i_miss_cnt_d;
    logic [CNT_W-1:0] d_miss_cnt_q, d_miss_cnt_d;

    // Saturating counters; a miss is counted on the cycle the FSM leaves IDLE for it.
    always_comb begin
        i_miss_cnt_d = i_miss_cnt_q;
        d_miss_cnt_d = d_miss_cnt_q;
        if (i_miss_c && (i_miss_cnt_q != {CNT_W{1'b1}})) begin
            i_miss_cnt_d = i_miss_cnt_q + CNT_W'(1);
        end
        if (d_miss_c && (d_miss_cnt_q != {CNT_W{1'b1}})) begin
            d_miss_cnt_d = d_miss_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_miss_cnt_q <= '0;
            d_miss_cnt_q <= '0;
        end else begin
            i_miss_cnt_q <= i_miss_cnt_d;
            d_miss_cnt_q <= d_miss_cnt_d;
        end
    end

    assign i_miss_cnt = i_miss_cnt_q;
    assign d_miss_cnt = d_miss_cnt_q;
`else
    logic unused_miss;
    assign unused_miss = d_miss_c ^ i_miss_c ^ (CNT_W == 0);
`endif

endmodule

// File: tb/tb_cache_controller.sv
// tb_cache_controller: directed scenario bench with a latency-programmable memory model.
// Counter checks are compiled in when CACHE_CTRL_MISS_CNT_EN is defined.
module tb_cache_controller;

    localparam int unsigned LINE_W  = 64;
    localparam int unsigned LADDR_W = 14;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [15:0]        i_addr;
    logic               i_hit;
    logic               i_rdy;
    logic               i_fill_we;
    logic [15:0]        d_addr;
    logic               d_re;
    logic               d_we;
    logic               d_hit;
    logic               d_dirty;
    logic [10:0]        d_victim_tag;
    logic [LINE_W-1:0]  d_victim_line;
    logic               d_rdy;
    logic               d_fill_we;
    logic [LADDR_W-1:0] m_addr;
    logic               m_re;
    logic               m_we;
    logic [LINE_W-1:0]  m_wdata;
    logic [LINE_W-1:0]  m_rdata;
    logic               m_rdy;
`ifdef CACHE_CTRL_MISS_CNT_EN
    logic [15:0]        i_miss_cnt;
    logic [15:0]        d_miss_cnt;
`endif

    int   tests = 0;
    int   fails = 0;
    int   mem_lat = 4;
    int   mem_cnt = 0;
    logic mem_rdy_model = 1'b0;
    logic force_rdy = 1'b0;

    assign m_rdy   = mem_rdy_model | force_rdy;
    assign m_rdata = 64'h0123_4567_89AB_CDEF;

    cache_controller #(.LINE_W(LINE_W), .LADDR_W(LADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_addr(i_addr), .i_hit(i_hit), .i_rdy(i_rdy), .i_fill_we(i_fill_we),
        .d_addr(d_addr), .d_re(d_re), .d_we(d_we), .d_hit(d_hit), .d_dirty(d_dirty),
        .d_victim_tag(d_victim_tag), .d_victim_line(d_victim_line),
        .d_rdy(d_rdy), .d_fill_we(d_fill_we),
        .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_rdy(m_rdy)
`ifdef CACHE_CTRL_MISS_CNT_EN
        , .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory: pulses m_rdy on the mem_lat-th cycle of each continuous request.
    always @(posedge clk) begin
        #1;
        if (m_re | m_we) begin
            if (mem_rdy_model) mem_cnt = 1;
            else mem_cnt = mem_cnt + 1;
        end else begin
            mem_cnt = 0;
        end
        mem_rdy_model = (mem_cnt == mem_lat);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_addr = '0; i_hit = 1'b0; d_addr = '0; d_re = 1'b0; d_we = 1'b0;
        d_hit = 1'b0; d_dirty = 1'b0; d_victim_tag = '0; d_victim_line = '0;
        cyc(); cyc();
        #1;
        tests++; if ({m_re, m_we, i_fill_we, d_fill_we, i_rdy, d_rdy} !== 6'b0) begin
            fails++; $display("FAIL reset_strobes: got %b exp 000000", {m_re, m_we, i_fill_we, d_fill_we, i_rdy, d_rdy});
        end
        tests++; if (m_addr !== 14'h0 || m_wdata !== 64'h0) begin
            fails++; $display("FAIL reset_bus: got addr %h wdata %h exp 0 0", m_addr, m_wdata);
        end
        rst_n = 1'b1;
        i_hit = 1'b1;
        #1;
        tests++; if (i_rdy !== 1'b1 || d_rdy !== 1'b1) begin
            fails++; $display("FAIL reset_release_idle: got i_rdy %b d_rdy %b exp 1 1", i_rdy, d_rdy);
        end
        cyc();
    endtask

    task automatic test_hit();
        i_hit = 1'b1; d_re = 1'b0; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin d_re = 1'b1; d_hit = 1'b1; end
            #1;
            tests++; if ({i_rdy, d_rdy, m_re, m_we} !== 4'b1100) begin
                fails++; $display("FAIL hit_cycle%0d: got rdy/re/we %b exp 1100", k, {i_rdy, d_rdy, m_re, m_we});
            end
            cyc();
        end
        d_re = 1'b0; d_hit = 1'b0;
        force_rdy = 1'b1;
        #1;
        tests++; if (i_fill_we !== 1'b0 || d_fill_we !== 1'b0) begin
            fails++; $display("FAIL idle_mrdy_strobe: got i %b d %b exp 0 0", i_fill_we, d_fill_we);
        end
        cyc();
        force_rdy = 1'b0;
        #1;
        tests++; if ({m_re, m_we, i_rdy} !== 3'b001) begin
            fails++; $display("FAIL idle_mrdy_ignored: got re/we/i_rdy %b exp 001", {m_re, m_we, i_rdy});
        end
        cyc();
    endtask

    task automatic test_i_fill();
        int fills;
        fills = 0;
        mem_lat = 4; i_hit = 1'b0; i_addr = 16'h0124;
        #1;
        tests++; if ({i_rdy, d_rdy, m_re} !== 3'b010) begin
            fails++; $display("FAIL imiss_idle: got i_rdy/d_rdy/m_re %b exp 010", {i_rdy, d_rdy, m_re});
        end
        cyc();
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) i_addr = 16'hFFFF;
            #1;
            tests++; if (m_re !== 1'b1 || m_we !== 1'b0 || m_addr !== 14'h0049 || i_rdy !== 1'b0) begin
                fails++; $display("FAIL ifill_cycle%0d: got re %b we %b addr %h i_rdy %b exp 1 0 0049 0", k, m_re, m_we, m_addr, i_rdy);
            end
            tests++; if (i_fill_we !== (k == 4) || d_fill_we !== 1'b0) begin
                fails++; $display("FAIL ifill_strobe%0d: got i %b d %b exp %b 0", k, i_fill_we, d_fill_we, (k == 4));
            end
            if (i_fill_we === 1'b1) fills++;
            if (k == 4) i_hit = 1'b1;
            cyc();
        end
        #1;
        tests++; if (i_rdy !== 1'b1 || m_re !== 1'b0 || i_fill_we !== 1'b0 || fills != 1) begin
            fails++; $display("FAIL ifill_done: got i_rdy %b m_re %b strobe %b fills %0d exp 1 0 0 1", i_rdy, m_re, i_fill_we, fills);
        end
        i_addr = 16'h0124;
        cyc();
    endtask

    task automatic test_d_writeback();
        mem_lat = 4; i_hit = 1'b1;
        d_re = 1'b1; d_hit = 1'b0; d_dirty = 1'b1; d_victim_tag = 11'h005; d_addr = 16'h0318;
        d_victim_line = 64'hDEAD_BEEF_0123_4567;
        #1;
        tests++; if (d_rdy !== 1'b0 || i_rdy !== 1'b0) begin
            fails++; $display("FAIL dmiss_idle: got d_rdy %b i_rdy %b exp 0 0", d_rdy, i_rdy);
        end
        cyc();
        // Write-back line address is {victim tag, d_addr[4:2]} = {11'h005, 3'b110}.
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) begin d_addr = 16'h0000; d_victim_tag = 11'h7FF; d_victim_line = '0; end
            #1;
            tests++; if (m_we !== 1'b1 || m_re !== 1'b0 || m_addr !== 14'h002E || m_wdata !== 64'hDEAD_BEEF_0123_4567) begin
                fails++; $display("FAIL dwb_cycle%0d: got we %b re %b addr %h wdata %h exp 1 0 002e deadbeef01234567", k, m_we, m_re, m_addr, m_wdata);
            end
            tests++; if ({d_rdy, i_rdy, d_fill_we} !== 3'b000) begin
                fails++; $display("FAIL dwb_rdy%0d: got %b exp 000", k, {d_rdy, i_rdy, d_fill_we});
            end
            cyc();
        end
        for (int k = 1; k <= 4; k++) begin
            #1;
            tests++; if (m_re !== 1'b1 || m_we !== 1'b0 || m_addr !== 14'h00C6) begin
                fails++; $display("FAIL dfill_cycle%0d: got re %b we %b addr %h exp 1 0 00c6", k, m_re, m_we, m_addr);
            end
            tests++; if (d_fill_we !== (k == 4) || i_fill_we !== 1'b0 || d_rdy !== 1'b0) begin
                fails++; $display("FAIL dfill_strobe%0d: got d %b i %b d_rdy %b exp %b 0 0", k, d_fill_we, i_fill_we, d_rdy, (k == 4));
            end
            if (k == 4) begin d_hit = 1'b1; d_addr = 16'h0318; end
            cyc();
        end
        #1;
        tests++; if (d_rdy !== 1'b1 || i_rdy !== 1'b1 || m_re !== 1'b0 || m_we !== 1'b0) begin
            fails++; $display("FAIL dfill_done: got d_rdy %b i_rdy %b re %b we %b exp 1 1 0 0", d_rdy, i_rdy, m_re, m_we);
        end
        d_re = 1'b0; d_dirty = 1'b0; d_hit = 1'b0;
        cyc();
    endtask

    task automatic test_priority();
        mem_lat = 2;
        i_hit = 1'b0; i_addr = 16'h0200;
        d_we = 1'b1; d_hit = 1'b0; d_dirty = 1'b0; d_addr = 16'h0400;
        #1;
        tests++; if (i_rdy !== 1'b0 || d_rdy !== 1'b0) begin
            fails++; $display("FAIL prio_idle: got i_rdy %b d_rdy %b exp 0 0", i_rdy, d_rdy);
        end
        cyc();
        for (int k = 1; k <= 2; k++) begin
            #1;
            tests++; if (m_re !== 1'b1 || m_addr !== 14'h0100 || i_rdy !== 1'b0 || i_fill_we !== 1'b0 || d_fill_we !== (k == 2)) begin
                fails++; $display("FAIL prio_dfill%0d: got re %b addr %h i_rdy %b ifw %b dfw %b exp 1 0100 0 0 %b", k, m_re, m_addr, i_rdy, i_fill_we, d_fill_we, (k == 2));
            end
            if (k == 2) d_hit = 1'b1;
            cyc();
        end
        #1;
        tests++; if (d_rdy !== 1'b1 || i_rdy !== 1'b0 || m_re !== 1'b0) begin
            fails++; $display("FAIL prio_between: got d_rdy %b i_rdy %b m_re %b exp 1 0 0", d_rdy, i_rdy, m_re);
        end
        cyc();
        for (int k = 1; k <= 2; k++) begin
            #1;
            tests++; if (m_re !== 1'b1 || m_addr !== 14'h0080 || i_rdy !== 1'b0 || d_fill_we !== 1'b0 || i_fill_we !== (k == 2)) begin
                fails++; $display("FAIL prio_ifill%0d: got re %b addr %h i_rdy %b dfw %b ifw %b exp 1 0080 0 0 %b", k, m_re, m_addr, i_rdy, d_fill_we, i_fill_we, (k == 2));
            end
            if (k == 2) i_hit = 1'b1;
            cyc();
        end
        #1;
        tests++; if (i_rdy !== 1'b1 || d_rdy !== 1'b1) begin
            fails++; $display("FAIL prio_done: got i_rdy %b d_rdy %b exp 1 1", i_rdy, d_rdy);
        end
        d_we = 1'b0; d_hit = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        int  seen;
        bit  done;
        mem_lat = 6; i_hit = 1'b1;
        d_re = 1'b1; d_hit = 1'b0; d_dirty = 1'b0; d_addr = 16'h0318;
        cyc(); cyc();
        #1;
        tests++; if (m_re !== 1'b1) begin
            fails++; $display("FAIL rstmid_pre: got m_re %b exp 1", m_re);
        end
        rst_n = 1'b0;
        #1;
        tests++; if ({m_re, m_we, i_fill_we, d_fill_we, i_rdy, d_rdy} !== 6'b0 || m_addr !== 14'h0) begin
            fails++; $display("FAIL rstmid_abort: got strobes %b addr %h exp 000000 0000", {m_re, m_we, i_fill_we, d_fill_we, i_rdy, d_rdy}, m_addr);
        end
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            if (d_fill_we === 1'b1) seen++;
        end
        d_re = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (d_fill_we === 1'b1 || m_re === 1'b1) seen++;
            cyc();
        end
        tests++; if (seen != 0 || d_rdy !== 1'b1 || i_rdy !== 1'b1) begin
            fails++; $display("FAIL rstmid_idle: got stray %0d d_rdy %b i_rdy %b exp 0 1 1", seen, d_rdy, i_rdy);
        end
        d_re = 1'b1; d_hit = 1'b0; d_addr = 16'h0318;
        #1;
        tests++; if (d_rdy !== 1'b0) begin
            fails++; $display("FAIL rstmid_first: got d_rdy %b exp 0", d_rdy);
        end
        cyc();
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (d_fill_we === 1'b1) begin
                done = 1'b1;
                d_hit = 1'b1;
            end
            cyc();
        end
        tests++; if (!done || m_addr !== 14'h00C6) begin
            fails++; $display("FAIL rstmid_refill: got done %b addr %h exp 1 00c6", done, m_addr);
        end
        d_re = 1'b0; d_hit = 1'b0;
        cyc();
    endtask

`ifdef CACHE_CTRL_MISS_CNT_EN
    task automatic test_miss_cnt();
        rst_n = 1'b0; i_hit = 1'b1; d_re = 1'b0; d_hit = 1'b0; d_dirty = 1'b0;
        cyc();
        rst_n = 1'b1; mem_lat = 1;
        #1;
        tests++; if (i_miss_cnt !== 16'h0 || d_miss_cnt !== 16'h0) begin
            fails++; $display("FAIL cnt_reset: got i %h d %h exp 0 0", i_miss_cnt, d_miss_cnt);
        end
        cyc();
        for (int k = 0; k < 3; k++) begin
            i_hit = 1'b0; i_addr = 16'h1000 + 16'(k * 4);
            cyc();
            i_hit = 1'b1;
            cyc();
        end
        d_re = 1'b1; d_hit = 1'b0; d_dirty = 1'b0;
        cyc();
        d_hit = 1'b1;
        cyc();
        d_hit = 1'b0; d_dirty = 1'b1;
        cyc();
        cyc();
        d_hit = 1'b1;
        cyc();
        d_re = 1'b0; d_dirty = 1'b0;
        #1;
        tests++; if (i_miss_cnt !== 16'd3 || d_miss_cnt !== 16'd2) begin
            fails++; $display("FAIL cnt_value: got i %0d d %0d exp 3 2", i_miss_cnt, d_miss_cnt);
        end
        cyc();
        dut.i_miss_cnt_q = 16'hFFFF;
        dut.d_miss_cnt_q = 16'hFFFF;
        i_hit = 1'b0;
        cyc();
        i_hit = 1'b1;
        cyc();
        d_re = 1'b1; d_hit = 1'b0;
        cyc();
        d_hit = 1'b1;
        cyc();
        d_re = 1'b0; d_hit = 1'b0;
        #1;
        tests++; if (i_miss_cnt !== 16'hFFFF || d_miss_cnt !== 16'hFFFF) begin
            fails++; $display("FAIL cnt_saturate: got i %h d %h exp ffff ffff", i_miss_cnt, d_miss_cnt);
        end
        cyc();
    endtask
`endif

    initial begin
        test_reset();
        test_hit();
        test_i_fill();
        test_d_writeback();
        test_priority();
        test_reset_mid();
`ifdef CACHE_CTRL_MISS_CNT_EN
        test_miss_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
